// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, width helpers and the colour channel expansion
// used by the line scan-out block.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_BPC      = 2;

  function automatic int pix_w(input int bpc);
    return 3 * bpc;
  endfunction

  function automatic int row_w(input int v_active);
    return (v_active > 1) ? $clog2(v_active) : 1;
  endfunction

  // Left-justify the bpc-bit code, then OR in right-shifted copies so the
  // pattern repeats down to the LSB (full-scale code maps to 8'hFF).
  function automatic logic [7:0] expand_chan(input logic [7:0] chan, input int bpc);
    logic [7:0] lj;
    logic [7:0] res;
    lj  = chan << (8 - bpc);
    res = lj;
    for (int k = 1; k < 8; k++) begin
      if (k * bpc < 8) res = res | (lj >> (k * bpc));
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with active, sync and line strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           pixelCLK,
  input  logic           RST,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           active,
  output logic           hs_on,
  output logic           vs_on,
  output logic           fetch_point,
  output logic           line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // v starts on the last blank line so row 0 is fetched before the first frame
  always_ff @(posedge pixelCLK or posedge RST) begin
    if (RST) begin
      h <= '0;
      v <= V_W'(V_TOTAL - 1);
    end else if (h == H_W'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign active      = (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));
  assign hs_on       = (h >= H_W'(H_ACTIVE + H_FP)) && (h < H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on       = (v >= V_W'(V_ACTIVE + V_FP)) && (v < V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign fetch_point = (h == H_W'(H_ACTIVE));
  assign line_end    = (h == H_W'(H_TOTAL - 1));

endmodule

// File: rtl/vga_line_scanout.sv
// Parametrised VGA scan-out: fetches each upcoming row into a double line
// buffer and drives registered DAC outputs. TEST_PATTERN_EN adds colour bars.
//
// state       | meaning
// FETCH_IDLE  | no row outstanding
// FETCH_REQ   | line_req high, waiting for line_valid or the line deadline
module vga_line_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int BPC      = DEF_BPC,
  parameter int SYNC_POL = 0,
  localparam int PIX_W   = pix_w(BPC),
  localparam int ROW_W   = row_w(V_ACTIVE)
) (
  input  logic                      pixelCLK,
  input  logic                      RST,
`ifdef TEST_PATTERN_EN
  input  logic                      test_en,
`endif
  output logic                      line_req,
  output logic [ROW_W-1:0]          line_row,
  input  logic [H_ACTIVE*PIX_W-1:0] line_data,
  input  logic                      line_valid,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK_N,
  output logic                      VGA_SYNC_N,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      underrun,
  output logic                      underrun_sticky
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int HA_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W  = H_ACTIVE * PIX_W;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic {
    FETCH_IDLE,
    FETCH_REQ
  } fetch_state_t;

  fetch_state_t state, state_nxt;

  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic              active, hs_on, vs_on, fetch_point, line_end;
  logic [V_W-1:0]    nr;
  logic              nr_active;
  logic              capture, late;
  logic [LINE_W-1:0] next_buf, cur_buf;
  logic              next_full;
  logic [HA_W-1:0]   h_idx;
  logic [PIX_W-1:0]  pix;
  logic [7:0]        r_nxt, g_nxt, b_nxt;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_timing (
    .pixelCLK    (pixelCLK),
    .RST         (RST),
    .h           (h),
    .v           (v),
    .active      (active),
    .hs_on       (hs_on),
    .vs_on       (vs_on),
    .fetch_point (fetch_point),
    .line_end    (line_end)
  );

  always_comb begin
    nr = v + 1'b1;
    if (v == V_W'(V_TOTAL - 1)) nr = '0;
  end

  assign nr_active = (nr < V_W'(V_ACTIVE));

  always_ff @(posedge pixelCLK or posedge RST) begin
    if (RST) state <= FETCH_IDLE;
    else     state <= state_nxt;
  end

  // A valid on the deadline cycle itself still wins over the underrun.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    late      = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (fetch_point && nr_active) state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (line_valid) begin
          capture   = 1'b1;
          state_nxt = FETCH_IDLE;
        end else if (line_end) begin
          late      = 1'b1;
          state_nxt = FETCH_IDLE;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  assign line_req = (state == FETCH_REQ);

  always_ff @(posedge pixelCLK or posedge RST) begin
    if (RST) begin
      line_row        <= '0;
      next_buf        <= '0;
      cur_buf         <= '0;
      next_full       <= 1'b0;
      underrun        <= 1'b0;
      underrun_sticky <= 1'b0;
    end else begin
      underrun <= late;
      if (late) underrun_sticky <= 1'b1;
      if (state == FETCH_IDLE && state_nxt == FETCH_REQ) line_row <= nr[ROW_W-1:0];
      if (line_end) begin
        if (capture)        cur_buf <= line_data;
        else if (late)      cur_buf <= '0;
        else if (next_full) cur_buf <= next_buf;
        next_full <= 1'b0;
      end else if (capture) begin
        next_buf  <= line_data;
        next_full <= 1'b1;
      end
    end
  end

  assign h_idx = h[HA_W-1:0];

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [2:0] bar;
`endif

  always_comb begin
    pix = '0;
    if (h < H_W'(H_ACTIVE)) pix = cur_buf[h_idx*PIX_W +: PIX_W];
    r_nxt = expand_chan(8'(pix[3*BPC-1 -: BPC]), BPC);
    g_nxt = expand_chan(8'(pix[2*BPC-1 -: BPC]), BPC);
    b_nxt = expand_chan(8'(pix[BPC-1:0]), BPC);
`ifdef TEST_PATTERN_EN
    bar = 3'(h / H_W'(BAR_W));
    if (test_en) begin
      r_nxt = {8{bar[2]}};
      g_nxt = {8{bar[1]}};
      b_nxt = {8{bar[0]}};
    end
`endif
  end

  // Single output stage keeps colour, blank and syncs aligned to (h,v) one cycle late
  always_ff @(posedge pixelCLK or posedge RST) begin
    if (RST) begin
      VGA_HS      <= ~SYNC_ACT;
      VGA_VS      <= ~SYNC_ACT;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_HS      <= hs_on ? SYNC_ACT : ~SYNC_ACT;
      VGA_VS      <= vs_on ? SYNC_ACT : ~SYNC_ACT;
      VGA_BLANK_N <= active;
      VGA_R       <= active ? r_nxt : 8'h00;
      VGA_G       <= active ? g_nxt : 8'h00;
      VGA_B       <= active ? b_nxt : 8'h00;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_line_scanout.sv
// Randomised bench for vga_line_scanout on a tiny raster, checked against a
// cycle-count raster model and a per-row fetch-deadline model.
module tb_vga_line_scanout;

  localparam int HA = 8, HF = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VBP = 1;
  localparam int BPC = 2, PW = 3 * BPC;
  localparam int HT = HA + HF + HSW + HBP;
  localparam int VT = VA + VF + VSW + VBP;
  localparam int MAX_D = HT - 1 - (HA + 1);

  logic             pixelCLK = 1'b0;
  logic             RST = 1'b1;
  logic             line_req;
  logic [1:0]       line_row;
  logic [HA*PW-1:0] line_data = '0;
  logic             line_valid = 1'b0;
  logic             VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]       VGA_R, VGA_G, VGA_B;
  logic             underrun, underrun_sticky;
`ifdef TEST_PATTERN_EN
  logic             test_en = 1'b0;
`endif

  always #5 pixelCLK = ~pixelCLK;

  vga_line_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VBP),
    .BPC (BPC), .SYNC_POL (0)
  ) dut (
    .pixelCLK        (pixelCLK),
    .RST             (RST),
`ifdef TEST_PATTERN_EN
    .test_en         (test_en),
`endif
    .line_req        (line_req),
    .line_row        (line_row),
    .line_data       (line_data),
    .line_valid      (line_valid),
    .VGA_HS          (VGA_HS),
    .VGA_VS          (VGA_VS),
    .VGA_BLANK_N     (VGA_BLANK_N),
    .VGA_SYNC_N      (VGA_SYNC_N),
    .VGA_R           (VGA_R),
    .VGA_G           (VGA_G),
    .VGA_B           (VGA_B),
    .underrun        (underrun),
    .underrun_sticky (underrun_sticky)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int mh, mv, ph, pv, fidx, cur_d, age, under_seen, blank_cnt;
  bit cur_fetch, sticky_m, req_prev, frame_seen, px_done, tp_now, tp_prev;
  int row_seed [VA];
  bit row_black [VA];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_row(input int v);
    return (v == VT - 1) ? 0 : v + 1;
  endfunction

  function automatic logic [5:0] pix_val(input int r, input int i, input int seed);
    logic [1:0] rr, ii;
    rr = 2'(r);
    ii = 2'(i);
    return {rr, ii, 2'b01} ^ 6'(seed);
  endfunction

  function automatic logic [7:0] widen(input logic [1:0] c);
    return 8'(int'(c) * 255 / 3);
  endfunction

  function automatic int pick_delay(input int frame, input int row);
    if (frame == 0) return 3;
    if (frame == 1) return (row == 1) ? MAX_D + 2 : (row == 2) ? MAX_D : 3;
    return $urandom_range(0, MAX_D + 2);
  endfunction

  function automatic logic [HA*PW-1:0] build_line(input int r);
    logic [HA*PW-1:0] ld;
    ld = '0;
    for (int i = 0; i < HA; i++) ld[i*PW +: PW] = pix_val(r, i, row_seed[r]);
    return ld;
  endfunction

  // Decide, at the start of each line, the source latency for the row fetched in it
  task automatic begin_line();
    int nr;
    nr = next_row(mv);
    cur_fetch = (nr < VA);
    if (cur_fetch) begin
      if (nr == 0) fidx++;
      cur_d = pick_delay(fidx, nr);
      row_seed[nr]  = (fidx < 2) ? 0 : int'($urandom_range(0, 63));
      row_black[nr] = (HA + 1 + cur_d > HT - 1);
    end
  endtask

  task automatic release_reset(input int start_frame);
    repeat (2) @(posedge pixelCLK);
    @(negedge pixelCLK);
    line_valid = 1'b0;
    RST = 1'b0;
    mh = 0; mv = VT - 1; fidx = start_frame;
    sticky_m = 0; req_prev = 0; age = 0; frame_seen = 0; blank_cnt = 0;
    begin_line();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_line_req"}, line_req, 0);
    check({tag, "_blank_n"}, VGA_BLANK_N, 0);
    check({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
    check({tag, "_hs_vs"}, {VGA_HS, VGA_VS}, 2'b11);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_sticky"}, underrun_sticky, 0);
  endtask

  task automatic step();
    logic [7:0] er, eg, eb;
    logic [5:0] p;
    bit act, exp_req, exp_under;
    int k;
    tp_prev = tp_now;
    @(posedge pixelCLK);
    #1;
    ph = mh; pv = mv;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    exp_under = 0;
    if (mh == 0) begin
      exp_under = cur_fetch && (HA + 1 + cur_d > HT - 1);
      begin_line();
    end
    if (exp_under) sticky_m = 1;

    act = (ph < HA) && (pv < VA);
    er = 0; eg = 0; eb = 0;
    if (act) begin
      if (tp_prev) begin
        k  = ph / (HA / 8);
        er = ((k & 4) != 0) ? 8'hFF : 8'h00;
        eg = ((k & 2) != 0) ? 8'hFF : 8'h00;
        eb = ((k & 1) != 0) ? 8'hFF : 8'h00;
      end else if (!row_black[pv]) begin
        p  = pix_val(pv, ph, row_seed[pv]);
        er = widen(p[5:4]);
        eg = widen(p[3:2]);
        eb = widen(p[1:0]);
      end
    end
    check("blank_n", VGA_BLANK_N, act);
    check("hs", VGA_HS, !((ph >= HA + HF) && (ph < HA + HF + HSW)));
    check("vs", VGA_VS, !((pv >= VA + VF) && (pv < VA + VF + VSW)));
    check("red", VGA_R, er);
    check("green", VGA_G, eg);
    check("blue", VGA_B, eb);
    check("sync_n", VGA_SYNC_N, 0);

    if (!px_done && act && !tp_prev && pv == 2 && ph == 3 && fidx == 0) begin
      check("px_r2_i3", {VGA_R, VGA_G, VGA_B}, 24'hAAFF55);
      px_done = 1;
    end

    if (VGA_BLANK_N) blank_cnt++;
    if (mh == 0 && mv == 0) begin
      if (frame_seen) check("blank_per_frame", blank_cnt, HA * VA);
      frame_seen = 1;
      blank_cnt  = 0;
    end

    exp_req = cur_fetch && (mh >= HA + 1) && (mh <= HA + 1 + cur_d);
    check("line_req", line_req, exp_req);
    if (exp_req) check("line_row", line_row, next_row(mv));
    check("underrun", underrun, exp_under);
    check("sticky", underrun_sticky, sticky_m);
    if (underrun) under_seen++;

    // Line source: answers cur_d cycles after the request appears, sprays junk otherwise
    if (line_req) begin
      age = req_prev ? age + 1 : 0;
      line_valid = (age == cur_d);
      line_data  = line_valid ? build_line(int'(line_row)) : (HA*PW)'({$urandom(), $urandom()});
    end else begin
      age = 0;
      line_valid = ($urandom_range(0, 3) == 0);
      line_data  = (HA*PW)'({$urandom(), $urandom()});
    end
    req_prev = line_req;
  endtask

  initial begin
    bit found;
    under_seen = 0; px_done = 0; tp_now = 0; tp_prev = 0;
    cur_fetch = 0; cur_d = 0;
    for (int r = 0; r < VA; r++) begin
      row_seed[r]  = 0;
      row_black[r] = 0;
    end

    #12;
    check_reset_outputs("por");
    release_reset(-1);

    while (fidx < 2) step();
    check("underrun_count_f01", under_seen, 1);
    check("sticky_after_late", underrun_sticky, 1);
    check("px_directed_seen", px_done, 1);

    while (fidx < 5) step();

    found = 0;
    for (int i = 0; i < 3 * HT * VT && !found; i++) begin
      step();
      if (line_req && mh == HA + 2) found = 1;
    end
    check("req_before_reset", found, 1);
    #2;
    RST = 1'b1;
    line_valid = 1'b0;
    #1;
    check_reset_outputs("mid");
    release_reset(1);
    repeat (3 * HT * VT) step();

`ifdef TEST_PATTERN_EN
    tp_now  = 1;
    test_en = 1'b1;
    repeat (2 * HT * VT) step();
    tp_now  = 0;
    test_en = 1'b0;
    repeat (HT * VT) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_line_scanout.md
Name: vga_line_scanout

Overview:
- Parametrised successor to the fixed 640x480, 6-bit-colour frame-buffer display.
- Generates VGA H/V timing from parameters and fetches each upcoming row from the map generator over a req/valid handshake into a double line buffer.
- Expands BPC-bit channels to 8-bit VGA outputs; flags underruns when a row arrives late.
- Sits between the map generator (line source) and the board's VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- BPC, 2, stored bits per colour channel (1..8); PIX_W = 3*BPC
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- pixelCLK  in  1  pixel clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- line_req  out  1  request for row line_row; held until line_valid
- line_row  out  clog2(V_ACTIVE)  row being requested; stable while line_req high
- line_data  in  H_ACTIVE*PIX_W  pixel i at [i*PIX_W +: PIX_W]; R in MSBs, then G, then B
- line_valid  in  1  line_data valid; sampled only while line_req is high
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK_N  out  1  high in the active region
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8 each  colour channels
- underrun  out  1  one-cycle pulse when a row misses its deadline
- underrun_sticky  out  1  set by any underrun; cleared only by RST

Behaviour:
- Timing counters
  - h counts 0..H_TOTAL-1 and v counts 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (V_TOTAL likewise).
  - Order is active, FP, sync, BP. v increments when h wraps; v wraps to 0 after V_TOTAL-1.
  - Active when h<H_ACTIVE and v<V_ACTIVE. HS is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VS is analogous on v.
- Reset
  - h=0, v=V_TOTAL-1, both line buffers zero, line_req=0, underrun=0, underrun_sticky=0.
  - Colour outputs 0, VGA_BLANK_N=0, HS/VS at their inactive level (!SYNC_POL).
- Fetch
  - At h==H_ACTIVE, if the next row nr is active (nr = v+1 when v+1<V_ACTIVE, 0 when v==V_TOTAL-1), assert line_req with line_row=nr.
  - On the first cycle where line_req && line_valid, capture line_data into the next buffer, set next_full, and drop line_req the following cycle.
  - line_valid is ignored while line_req is low.
- Swap
  - At h==H_TOTAL-1: if next_full, copy next into current and clear next_full.
  - If line_req is still high (row late): pulse underrun, set underrun_sticky, load current with zeros (black row), drop line_req, and discard any later valid for that row.
  - line_valid arriving on the h==H_TOTAL-1 cycle itself counts as in time and is loaded directly into current.
- Output pipeline
  - Exactly one register stage.
  - Colour, VGA_BLANK_N, HS and VS all reflect counter state (h,v) one cycle later, so they stay aligned.
  - Colour is 0 whenever not active.
- Channel expansion
  - Each BPC-bit channel is left-justified and bit-replicated to 8 bits, e.g. BPC=2: 2'b10 -> 8'b10101010; 2'b11 -> 8'hFF.
- Reset asserted mid-frame returns to the reset state immediately; any outstanding request is abandoned.

Optional Feature:
- TEST_PATTERN_EN defined:
  - Adds input test_en.
  - While test_en=1, the active region shows 8 vertical colour bars, each H_ACTIVE/8 wide. Bar k: R=k[2], G=k[1], B=k[0], each expanded to 0x00/0xFF.
  - Fetch and underrun logic keep running; underrun is still reported.
- TEST_PATTERN_EN undefined: no test_en port; output is always line-buffer data.

Decomposition:
- Package vga_pkg:
  - default 640x480 timing constants
  - PIX_W and ROW_W derivation
  - a channel-expansion function (BPC -> 8 bit replication)
- Sub-module vga_timing_gen:
  - holds the h/v counters, active flag and raw HS/VS
  - emits a fetch_point strobe (h==H_ACTIVE) and a line_end strobe (h==H_TOTAL-1)
- Buffering, handshake and colour pipeline remain in vga_line_scanout.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, BPC=2), 2 frames -> HS low for 2 clocks at h=10..11, VS low on v=5, VGA_BLANK_N high exactly 32 cycles per frame, all one cycle after counter state.
- Source answers line_valid 3 cycles after line_req, row r pixel i = {r[1:0],i[1:0],2'b01} -> line_row sequence 0,1,2,3 and 0 again next frame; pixel (r=2,i=3) yields R=0xAA, G=0xFF, B=0x55.
- Source withholds valid for row 1 until past h==H_TOTAL-1 -> underrun pulses once, sticky=1, row 1 displays all zeros, row 2 fetched normally.
- line_valid asserted exactly on the h==H_TOTAL-1 cycle -> no underrun; data is displayed on the next row.
- RST pulsed mid-row with line_req high -> line_req=0, outputs black and blank, sticky cleared; first request after release is row 0.
- TEST_PATTERN_EN with test_en=1, H_ACTIVE=8 -> pixel k outputs R/G/B = {k[2],k[1],k[0]} x 0xFF.
